// File: rtl/sram_b_burst_reader.sv
// Burst read engine: turns one (addr, len) request into back-to-back SRAM reads, streams words out in address order.
// Latency: request accepted at edge 0 -> CE1 in cycle 1 -> OUT_VALID in cycle 3; DONE the cycle after the last pop.
// Backpressure: full valid/ready on the output; issues stop while 4-entry FIFO plus in-flight read is full, nothing dropped.
//
// Ports: CLK/RSTN (async active-low); REQ_* request handshake (REQ_LEN = words-1);
// OUT_* data stream with OUT_LAST on the final word; DONE one-cycle drain pulse;
// CE1/A1/Q1 SRAM read port (Q1 valid the cycle after CE1); PERF_BUSY/PERF_STALL counters.
// Optional feature: define SRAM_B_BURST_READER_PERF_EN to build saturating perf counters
// (otherwise PERF_* are tied to zero).
module sram_b_burst_reader #(
    parameter int ABITS = 19,
    parameter int DBITS = 8,
    parameter int LBITS = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [ABITS-1:0] REQ_ADDR,
    input  logic [LBITS-1:0] REQ_LEN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [DBITS-1:0] OUT_DATA,
    output logic             OUT_LAST,
    output logic             DONE,
    output logic             CE1,
    output logic [ABITS-1:0] A1,
    input  logic [DBITS-1:0] Q1,
    output logic [31:0]      PERF_BUSY,
    output logic [31:0]      PERF_STALL
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ABITS-1:0] addr_q;
    logic [LBITS-1:0] remaining_q;
    logic             inflight_q;
    logic             inflight_last_q;

    // FIFO entry layout: {last, data}
    logic [DBITS:0]   fifo_mem [4];
    logic [1:0]       wr_ptr_q;
    logic [1:0]       rd_ptr_q;
    logic [2:0]       count_q;
    logic [DBITS:0]   head;

    logic             accept;
    logic             issue;
    logic             issue_last;
    logic             done_pulse;
    logic             push;
    logic             pop;
    logic [2:0]       credit_used;

    // Credit is taken from registered state only: a pop this cycle frees
    // its slot for issue in the next cycle, never the current one.
    assign credit_used = count_q + {2'b00, inflight_q};
    assign issue_last  = (remaining_q == '0);

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        issue      = 1'b0;
        done_pulse = 1'b0;
        REQ_READY  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                REQ_READY = 1'b1;
                if (REQ_VALID) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (credit_used < 3'd4) begin
                    issue = 1'b1;
                    if (issue_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if ((count_q == 3'd0) && !inflight_q) begin
                    done_pulse = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && issue_last;
            if (accept) begin
                addr_q      <= REQ_ADDR;
                remaining_q <= REQ_LEN;
            end else if (issue) begin
                addr_q <= addr_q + ABITS'(1);
                if (!issue_last) begin
                    remaining_q <= remaining_q - LBITS'(1);
                end
            end
        end
    end

    // Read data lands in the FIFO on the edge after its CE1 cycle.
    assign push = inflight_q;
    assign pop  = OUT_VALID && OUT_READY;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: outputs are masked whenever the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {inflight_last_q, Q1};
        end
    end

    assign head      = fifo_mem[rd_ptr_q];
    assign OUT_VALID = (count_q != 3'd0);
    assign OUT_DATA  = OUT_VALID ? head[DBITS-1:0] : '0;
    assign OUT_LAST  = OUT_VALID ? head[DBITS] : 1'b0;
    assign DONE      = done_pulse;
    assign CE1       = issue;
    assign A1        = addr_q;

`ifdef SRAM_B_BURST_READER_PERF_EN
    logic [31:0] busy_q;
    logic [31:0] stall_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            busy_q  <= 32'd0;
            stall_q <= 32'd0;
        end else begin
            if ((state_q != ST_IDLE) && (busy_q != 32'hFFFF_FFFF)) begin
                busy_q <= busy_q + 32'd1;
            end
            if (OUT_VALID && !OUT_READY && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign PERF_BUSY  = busy_q;
    assign PERF_STALL = stall_q;
`else
    assign PERF_BUSY  = 32'd0;
    assign PERF_STALL = 32'd0;
`endif

endmodule

// File: tb/tb_sram_b_burst_reader.sv
// Directed bench for sram_b_burst_reader with a one-cycle-latency SRAM model.
// Latency: checks cycle-exact timing from request acceptance to DONE.
// Backpressure: holds OUT_READY low for a window and checks stability and lossless delivery.
module tb_sram_b_burst_reader;

    localparam int ABITS = 19;
    localparam int DBITS = 8;
    localparam int LBITS = 16;

    logic             CLK = 1'b0;
    logic             RSTN;
    logic             REQ_VALID;
    logic             REQ_READY;
    logic [ABITS-1:0] REQ_ADDR;
    logic [LBITS-1:0] REQ_LEN;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [DBITS-1:0] OUT_DATA;
    logic             OUT_LAST;
    logic             DONE;
    logic             CE1;
    logic [ABITS-1:0] A1;
    logic [DBITS-1:0] Q1 = '0;
    logic [31:0]      PERF_BUSY;
    logic [31:0]      PERF_STALL;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    sram_b_burst_reader #(.ABITS(ABITS), .DBITS(DBITS), .LBITS(LBITS)) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .REQ_ADDR   (REQ_ADDR),
        .REQ_LEN    (REQ_LEN),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OUT_DATA   (OUT_DATA),
        .OUT_LAST   (OUT_LAST),
        .DONE       (DONE),
        .CE1        (CE1),
        .A1         (A1),
        .Q1         (Q1),
        .PERF_BUSY  (PERF_BUSY),
        .PERF_STALL (PERF_STALL)
    );

    // SRAM contents are a fixed function of the address.
    function automatic logic [DBITS-1:0] mem_val(input logic [ABITS-1:0] a);
        return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]} ^ 8'h3C;
    endfunction

    always @(posedge CLK) begin
        if (CE1) begin
            Q1 <= mem_val(A1);
        end
    end

    // Push into a full FIFO must never happen.
    always @(negedge CLK) begin
        if (RSTN) begin
            assert (!(dut.inflight_q && (dut.count_q == 3'd4))) else begin
                errors++;
                $error("FAIL fifo_overflow observed=1 expected=0");
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Issues one request with OUT_READY high and checks every cycle up to DONE.
    task automatic run_stream(input string name, input logic [ABITS-1:0] base, input int n);
        logic [ABITS-1:0] ea;
        REQ_ADDR  = base;
        REQ_LEN   = LBITS'(n - 1);
        REQ_VALID = 1'b1;
        step();
        REQ_VALID = 1'b0;
        for (int c = 1; c <= n + 4; c++) begin
            chk($sformatf("%s_ce1_c%0d", name, c), CE1, (c <= n));
            if (c <= n) begin
                ea = base + ABITS'(c - 1);
                chk($sformatf("%s_a1_c%0d", name, c), A1, ea);
            end
            chk($sformatf("%s_vld_c%0d", name, c), OUT_VALID, (c >= 3) && (c <= n + 2));
            if ((c >= 3) && (c <= n + 2)) begin
                ea = base + ABITS'(c - 3);
                chk($sformatf("%s_dat_c%0d", name, c), OUT_DATA, mem_val(ea));
                chk($sformatf("%s_last_c%0d", name, c), OUT_LAST, (c == n + 2));
            end
            chk($sformatf("%s_done_c%0d", name, c), DONE, (c == n + 3));
            step();
        end
        chk({name, "_idle_ready"}, REQ_READY, 1'b1);
    endtask

    initial begin
        int  idx;
        bit  done_seen;

        RSTN      = 1'b0;
        REQ_VALID = 1'b0;
        REQ_ADDR  = '0;
        REQ_LEN   = '0;
        OUT_READY = 1'b1;
        #2;
        chk("rst_req_ready", REQ_READY, 1'b1);
        chk("rst_out_valid", OUT_VALID, 1'b0);
        chk("rst_out_data", OUT_DATA, 8'h00);
        chk("rst_out_last", OUT_LAST, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_ce1", CE1, 1'b0);
        chk("rst_a1", A1, 19'h0);
        chk("rst_perf_busy", PERF_BUSY, 32'd0);
        chk("rst_perf_stall", PERF_STALL, 32'd0);
        step();
        step();
        RSTN = 1'b1;
        step();

        // Single word and 16-word streaming bursts.
        run_stream("single", 19'h00010, 1);
        run_stream("stream", 19'h01000, 16);

        // Backpressure: OUT_READY low in cycles 3..12.
        REQ_ADDR  = 19'h02000;
        REQ_LEN   = 16'd9;
        REQ_VALID = 1'b1;
        step();
        REQ_VALID = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c == 3) begin
                OUT_READY = 1'b0;
            end
            chk($sformatf("bp_ce1_c%0d", c), CE1, (c <= 4));
            if (c >= 3) begin
                chk($sformatf("bp_hold_vld_c%0d", c), OUT_VALID, 1'b1);
                chk($sformatf("bp_hold_dat_c%0d", c), OUT_DATA, mem_val(19'h02000));
                chk($sformatf("bp_hold_last_c%0d", c), OUT_LAST, 1'b0);
            end
            step();
        end
        OUT_READY = 1'b1;
        chk("bp_ce1_c13_no_same_cycle_credit", CE1, 1'b0);
        idx       = 0;
        done_seen = 1'b0;
        for (int n = 0; (n < 40) && !done_seen; n++) begin
            if (OUT_VALID) begin
                chk($sformatf("bp_dat_w%0d", idx), OUT_DATA, mem_val(19'h02000 + ABITS'(idx)));
                chk($sformatf("bp_last_w%0d", idx), OUT_LAST, (idx == 9));
                idx++;
            end
            if (DONE) begin
                done_seen = 1'b1;
                chk("bp_word_count", idx, 10);
            end
            step();
        end
        chk("bp_done_seen", done_seen, 1'b1);
`ifdef SRAM_B_BURST_READER_PERF_EN
        chk("bp_perf_stall", PERF_STALL, 32'd10);
        chk("perf_busy_nonzero", (PERF_BUSY != 32'd0), 1'b1);
`else
        chk("bp_perf_stall", PERF_STALL, 32'd0);
        chk("perf_busy_tied", PERF_BUSY, 32'd0);
`endif

        // Address wrap at the top of the space.
        run_stream("wrap", 19'h7FFFE, 4);

        // Reset in cycle 5 of a 32-word burst.
        REQ_ADDR  = 19'h03000;
        REQ_LEN   = 16'd31;
        REQ_VALID = 1'b1;
        step();
        REQ_VALID = 1'b0;
        step();
        step();
        step();
        step();
        chk("mid_ce1_before_rst", CE1, 1'b1);
        RSTN = 1'b0;
        #1;
        chk("mid_rst_req_ready", REQ_READY, 1'b1);
        chk("mid_rst_out_valid", OUT_VALID, 1'b0);
        chk("mid_rst_out_data", OUT_DATA, 8'h00);
        chk("mid_rst_out_last", OUT_LAST, 1'b0);
        chk("mid_rst_done", DONE, 1'b0);
        chk("mid_rst_ce1", CE1, 1'b0);
        chk("mid_rst_a1", A1, 19'h0);
        chk("mid_rst_perf_busy", PERF_BUSY, 32'd0);
        chk("mid_rst_perf_stall", PERF_STALL, 32'd0);
        step();
        chk("mid_rst_hold_done", DONE, 1'b0);
        RSTN = 1'b1;
        step();
        chk("post_rst_done", DONE, 1'b0);
        chk("post_rst_out_valid", OUT_VALID, 1'b0);
        run_stream("post_rst", 19'h00040, 1);

        // Request held while busy: second request accepted the cycle after DONE.
        REQ_ADDR  = 19'h00500;
        REQ_LEN   = 16'd1;
        REQ_VALID = 1'b1;
        step();
        REQ_ADDR  = 19'h00600;
        REQ_LEN   = 16'd0;
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("busy_req_ready_c%0d", c), REQ_READY, 1'b0);
            chk($sformatf("busy_done_c%0d", c), DONE, (c == 5));
            if (c == 3) begin
                chk("busy_dat_w0", OUT_DATA, mem_val(19'h00500));
            end
            if (c == 4) begin
                chk("busy_dat_w1", OUT_DATA, mem_val(19'h00501));
                chk("busy_last_w1", OUT_LAST, 1'b1);
            end
            step();
        end
        chk("busy_c6_req_ready", REQ_READY, 1'b1);
        chk("busy_c6_ce1", CE1, 1'b0);
        step();
        REQ_VALID = 1'b0;
        chk("busy2_ce1", CE1, 1'b1);
        chk("busy2_a1", A1, 19'h00600);
        step();
        step();
        chk("busy2_vld", OUT_VALID, 1'b1);
        chk("busy2_dat", OUT_DATA, mem_val(19'h00600));
        chk("busy2_last", OUT_LAST, 1'b1);
        step();
        chk("busy2_done", DONE, 1'b1);
        step();
        chk("busy2_idle", REQ_READY, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
